weight_loader: RTL and testbench

- Upstream fill stage for the PE weight buffer's write port (we_a/addr_a/wdata_a).
- Accepts a command (base address, word count), then consumes a narrow valid/ready weight stream from the DMA side.
- Packs IN_WIDTH beats into DATA_WIDTH words and writes them to consecutive buffer addresses.
- Signals completion to the controller with a one-cycle done pulse.

---
 rtl/weight_loader.sv | 181 ++++++++++++++++++
 tb/tb_weight_loader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_loader.sv
// ============================================================================
//  Module   : weight_loader
//  Purpose  : Fill stage for the PE weight buffer write port. Accepts a
//             (base address, word count) command, packs narrow stream beats
//             into buffer words and writes them to consecutive addresses.
//             Signals completion with a one-cycle done pulse.
//  Ports    : clk, rst              - clock, synchronous active-high reset
//             start, base_addr,     - command strobe / first address /
//             num_words               word count (0..2^ADDR_WIDTH)
//             busy, done            - status (busy in LOAD+DONE, done pulse)
//             s_valid/s_data/s_ready- incoming weight stream
//             we_a/addr_a/wdata_a   - buffer write port
//             checksum              - optional running beat sum
//  Options  : define WEIGHT_LOADER_CHECKSUM_EN to add the checksum output.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module weight_loader #(
    parameter int IN_WIDTH   = 32,
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   num_words,
    output logic                  busy,
    output logic                  done,
    input  logic                  s_valid,
    input  logic [IN_WIDTH-1:0]   s_data,
    output logic                  s_ready,
    output logic                  we_a,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic [DATA_WIDTH-1:0] wdata_a
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]           checksum
`endif
);

    localparam int BEATS  = DATA_WIDTH / IN_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH:0]   num_q;
    logic [ADDR_WIDTH:0]   word_idx_q;
    logic [BEAT_W-1:0]     beat_q;
    logic [DATA_WIDTH-1:0] pack_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  w_start_acc;
    logic                  w_accept;
    logic                  w_last_beat;
    logic                  w_last_word;
    logic [DATA_WIDTH-1:0] w_word;

    // Acceptance uses the state directly so s_ready never depends on s_valid.
    assign w_start_acc = (state_q == ST_IDLE) && start;
    assign w_accept    = (state_q == ST_LOAD) && s_valid;
    assign w_last_beat = (beat_q == BEAT_W'(BEATS - 1));
    assign w_last_word = ((word_idx_q + 1'b1) == num_q);

    // Partial word with the current beat merged into its slot; on the last
    // beat this is the complete word handed to the write port.
    always_comb begin
        w_word = pack_q;
        w_word[int'(beat_q)*IN_WIDTH +: IN_WIDTH] = s_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_ready = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (num_words == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (w_accept && w_last_beat && w_last_word) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q     <= '0;
            num_q      <= '0;
            word_idx_q <= '0;
            beat_q     <= '0;
            pack_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            we_q <= 1'b0;
            if (w_start_acc) begin
                base_q     <= base_addr;
                num_q      <= num_words;
                word_idx_q <= '0;
                beat_q     <= '0;
            end
            if (w_accept) begin
                pack_q <= w_word;
                if (w_last_beat) begin
                    beat_q     <= '0;
                    we_q       <= 1'b1;
                    // Address arithmetic wraps modulo 2^ADDR_WIDTH.
                    addr_q     <= base_q + word_idx_q[ADDR_WIDTH-1:0];
                    wdata_q    <= w_word;
                    word_idx_q <= word_idx_q + 1'b1;
                end else begin
                    beat_q <= beat_q + 1'b1;
                end
            end
        end
    end

    assign we_a    = we_q;
    assign addr_a  = addr_q;
    assign wdata_a = wdata_q;

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [31:0] w_beat32;
    logic [31:0] checksum_q;

    if (IN_WIDTH >= 32) begin : g_cks_trunc
        assign w_beat32 = s_data[31:0];
    end else begin : g_cks_ext
        assign w_beat32 = {{(32-IN_WIDTH){1'b0}}, s_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            checksum_q <= '0;
        end else if (w_start_acc) begin
            checksum_q <= '0;
        end else if (w_accept) begin
            checksum_q <= checksum_q + w_beat32;
        end
    end

    assign checksum = checksum_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_weight_loader.sv
`default_nettype none

module tb_weight_loader;

    localparam int IW    = 32;
    localparam int DW    = 128;
    localparam int AW    = 16;
    localparam int BEATS = DW / IW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   num_words = '0;
    logic          busy;
    logic          done;
    logic          s_valid = 1'b0;
    logic [IW-1:0] s_data = '0;
    logic          s_ready;
    logic          we_a;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] wdata_a;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [31:0]   checksum;
`endif

    weight_loader #(
        .IN_WIDTH   (IW),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .busy      (busy),
        .done      (done),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .we_a      (we_a),
        .addr_a    (addr_a),
        .wdata_a   (wdata_a)
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int unsigned   cyc;
    } wr_t;

    typedef struct {
        int unsigned cyc;
        logic [31:0] cks;
    } dn_t;

    wr_t wr_q[$];
    dn_t dn_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes or pulses done.
    always @(negedge clk) begin
        if (!rst) begin
            if (we_a) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    check("write_addr", DW'(addr_a), DW'(e.addr));
                    check("write_data", wdata_a, e.data);
                    check("write_cycle", DW'(cyc), DW'(e.cyc));
                end
            end
            if (done) begin
                if (dn_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    dn_t d;
                    d = dn_q.pop_front();
                    check("done_cycle", DW'(cyc), DW'(d.cyc));
                    check("busy_in_done", DW'(busy), 1);
                    check("ready_in_done", DW'(s_ready), 0);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
                    check("checksum", DW'(checksum), DW'(d.cks));
`endif
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},    DW'(busy),    0);
        check({tag, "_done"},    DW'(done),    0);
        check({tag, "_ready"},   DW'(s_ready), 0);
        check({tag, "_we"},      DW'(we_a),    0);
        check({tag, "_addr"},    DW'(addr_a),  0);
        check({tag, "_wdata"},   wdata_a,      0);
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        check({tag, "_cks"},     DW'(checksum), 0);
`endif
    endtask

    // Issues one command and its beats; entered and left at a negedge in IDLE.
    // gap_mode: 0 full rate, 1 three idle cycles before beat 2, 2 random gaps.
    task automatic run_cmd(input logic [AW-1:0] base, input int n, input int gap_mode,
                           input bit pattern, input bit poke);
        logic [DW-1:0] word;
        logic [31:0]   cks;
        logic [IW-1:0] d;
        logic [3:0]    nib;
        logic [AW-1:0] waddr;
        int            guard;
        int            b;
        int            gaps;
        cks  = '0;
        word = '0;
        start     = 1'b1;
        base_addr = base;
        num_words = n[AW:0];
        if (n == 0) dn_q.push_back('{cyc + 1, 32'h0});
        @(negedge clk);
        start     = 1'b0;
        base_addr = AW'($urandom);
        num_words = (AW+1)'($urandom);
        if (n == 0) begin
            check("zero_len_ready", DW'(s_ready), 0);
            check("zero_len_we", DW'(we_a), 0);
            @(negedge clk);
            check("zero_len_idle_busy", DW'(busy), 0);
            check("zero_len_idle_ready", DW'(s_ready), 0);
            return;
        end
        for (int w = 0; w < n; w++) begin
            for (int k = 0; k < BEATS; k++) begin
                b = w * BEATS + k;
                gaps = 0;
                if (gap_mode == 1 && b == 2) gaps = 3;
                else if (gap_mode == 2 && $urandom_range(0, 2) == 0) gaps = $urandom_range(1, 3);
                for (int g = 0; g < gaps; g++) begin
                    s_valid = 1'b0;
                    s_data  = IW'($urandom);
                    @(negedge clk);
                end
                nib = 4'(b + 1);
                d = pattern ? {8{nib}} : IW'($urandom);
                s_valid = 1'b1;
                s_data  = d;
                if (poke && !(w == n - 1 && k == BEATS - 1) && $urandom_range(0, 2) == 0) begin
                    start     = 1'b1;
                    base_addr = AW'($urandom);
                    num_words = (AW+1)'($urandom_range(0, 3));
                end
                guard = 0;
                while (!s_ready && guard < 20) begin
                    @(negedge clk);
                    guard++;
                end
                if (!s_ready) begin
                    check("ready_timeout", 0, 1);
                    s_valid = 1'b0;
                    start   = 1'b0;
                    return;
                end
                // Beat is taken at the coming edge.
                word[k*IW +: IW] = d;
                cks = cks + 32'(d);
                if (k == BEATS - 1) begin
                    waddr = base + AW'(w);
                    wr_q.push_back('{waddr, word, cyc + 1});
                    if (w == n - 1) dn_q.push_back('{cyc + 1, cks});
                end
                @(negedge clk);
                start = 1'b0;
            end
        end
        // DONE cycle: extra beats offered must not be taken.
        s_valid = 1'b1;
        s_data  = IW'($urandom);
        check("extra_beat_ready_done", DW'(s_ready), 0);
        @(negedge clk);
        check("extra_beat_ready_idle", DW'(s_ready), 0);
        check("busy_after_done", DW'(busy), 0);
        s_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [AW-1:0] base;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Basic load, then back-to-back with gaps, wrap, zero length.
        run_cmd(16'h0010, 2, 0, 1'b1, 1'b0);
        run_cmd(16'h0010, 2, 1, 1'b1, 1'b0);
        run_cmd(16'hFFFF, 2, 0, 1'b1, 1'b0);
        run_cmd(16'h1234, 0, 0, 1'b0, 1'b0);

        // Reset in the middle of the first word.
        start = 1'b1; base_addr = 16'h0020; num_words = 17'd3;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1;
            s_data  = IW'($urandom);
            @(negedge clk);
        end
        s_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midload_reset");
        rst = 1'b0;
        @(negedge clk);
        run_cmd(16'h0100, 1, 0, 1'b0, 1'b0);

        // Start pulses during LOAD must be ignored.
        run_cmd(16'h0040, 3, 2, 1'b0, 1'b1);

        // Randomised commands.
        for (int t = 0; t < 20; t++) begin
            n = $urandom_range(0, 5);
            base = ($urandom_range(0, 3) == 0) ? AW'(16'hFFFF - $urandom_range(0, 3)) : AW'($urandom);
            run_cmd(base, n, ($urandom_range(0, 1) == 0) ? 0 : 2, 1'b0, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end

        repeat (4) @(negedge clk);
        check("writes_drained", DW'(wr_q.size()), 0);
        check("dones_drained", DW'(dn_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
